// File: rtl/otter_hazard_pkg.sv
// Shared types and helpers for the OTTER hazard/forwarding unit.
package otter_hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        SB_STALL = 2'd2
    } hz_state_t;

    localparam int unsigned SEL_REGFILE = 0;

    function automatic int unsigned sel_width(input int unsigned n_fwd);
        return $clog2(n_fwd + 1);
    endfunction

endpackage

// File: rtl/fwd_sel_enc.sv
// Forwarding priority encoder: picks the youngest write-back stage writing rs.
module fwd_sel_enc
    import otter_hazard_pkg::*;
#(
    parameter int unsigned N_FWD = 2,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned SEL_W = sel_width(N_FWD)
) (
    input  logic [RA_W-1:0]       i_rs,
    input  logic [N_FWD*RA_W-1:0] i_fwd_rd,
    input  logic [N_FWD-1:0]      i_fwd_regWrite,
    output logic [SEL_W-1:0]      o_sel
);

    // Scan oldest to youngest so the youngest matching stage is the last assignment.
    always_comb begin
        o_sel = SEL_W'(SEL_REGFILE);
        for (int unsigned i = N_FWD; i >= 1; i--) begin
            if (i_fwd_regWrite[i-1] &&
                (i_fwd_rd[(i-1)*RA_W +: RA_W] != '0) &&
                (i_fwd_rd[(i-1)*RA_W +: RA_W] == i_rs)) begin
                o_sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// OTTER hazard unit: ID/EX forwarding selects, load-use and scoreboard stalls,
// drain handshake and saturating stall-cycle counters.
module hazard_fwd_unit
    import otter_hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned N_FWD   = 2,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned SEL_W  = sel_width(N_FWD)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_SRC*RA_W-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [NUM_SRC*RA_W-1:0]  ex_rs,
    input  logic [RA_W-1:0]          ex_rd,
    input  logic                     ex_memRead,
    input  logic                     ex_regWrite,
    input  logic [N_FWD*RA_W-1:0]    fwd_rd,
    input  logic [N_FWD-1:0]         fwd_regWrite,
    input  logic                     lng_issue,
    input  logic [RA_W-1:0]          lng_rd,
    input  logic                     lng_done,
    input  logic [RA_W-1:0]          lng_done_rd,
    input  logic                     flush,
    input  logic                     drain_req,
    output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel,
    output logic [NUM_SRC*SEL_W-1:0] id_fwd_sel,
    output logic                     stall,
    output logic                     drained,
    output logic                     sb_err,
    output logic [CNT_W-1:0]         cnt_lu,
    output logic [CNT_W-1:0]         cnt_sb
);

    localparam int unsigned NREG = 2 ** RA_W;

    logic [NREG-1:0]    r_pend;
    logic [NREG-1:0]    w_pend_nxt;
    logic               r_sb_err;
    logic               w_sb_err_evt;
    hz_state_t          r_state;
    hz_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt_lu;
    logic [CNT_W-1:0]   r_cnt_sb;
    logic [NUM_SRC-1:0] w_lu_k;
    logic [NUM_SRC-1:0] w_sb_k;
    logic               w_lu_hit;
    logic               w_sb_hit;
    logic               w_stall;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_sel_enc #(.N_FWD(N_FWD), .RA_W(RA_W), .SEL_W(SEL_W)) u_ex_enc (
            .i_rs           (ex_rs[k*RA_W +: RA_W]),
            .i_fwd_rd       (fwd_rd),
            .i_fwd_regWrite (fwd_regWrite),
            .o_sel          (ex_fwd_sel[k*SEL_W +: SEL_W])
        );

        fwd_sel_enc #(.N_FWD(N_FWD), .RA_W(RA_W), .SEL_W(SEL_W)) u_id_enc (
            .i_rs           (id_rs[k*RA_W +: RA_W]),
            .i_fwd_rd       (fwd_rd),
            .i_fwd_regWrite (fwd_regWrite),
            .o_sel          (id_fwd_sel[k*SEL_W +: SEL_W])
        );

        assign w_sb_k[k] = id_rs_used[k] && r_pend[id_rs[k*RA_W +: RA_W]] &&
                           (id_rs[k*RA_W +: RA_W] != '0);
        // A source already pending on the scoreboard is attributed to the scoreboard only.
        assign w_lu_k[k] = ex_memRead && ex_regWrite && (ex_rd != '0) && id_rs_used[k] &&
                           (id_rs[k*RA_W +: RA_W] == ex_rd) && !w_sb_k[k];
    end

    assign w_lu_hit = |w_lu_k;
    assign w_sb_hit = |w_sb_k;
    assign w_stall  = (w_lu_hit || w_sb_hit) && !flush;

    assign stall   = w_stall;
    assign drained = drain_req && (r_pend == '0) && !w_stall;
    assign sb_err  = r_sb_err;
    assign cnt_lu  = r_cnt_lu;
    assign cnt_sb  = r_cnt_sb;

    // Set is applied after clear so a same-cycle issue to the same reg wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (lng_done) begin
            w_pend_nxt[lng_done_rd] = 1'b0;
        end
        if (lng_issue && (lng_rd != '0)) begin
            w_pend_nxt[lng_rd] = 1'b1;
        end
    end

    assign w_sb_err_evt = lng_done && !r_pend[lng_done_rd];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (w_stall && w_sb_hit) begin
                    w_state_nxt = SB_STALL;
                end else if (w_stall && w_lu_hit) begin
                    w_state_nxt = LU_STALL;
                end
            end
            LU_STALL: begin
                w_state_nxt = (w_stall && w_sb_hit) ? SB_STALL : RUN;
            end
            SB_STALL: begin
                if (!w_stall) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pend   <= '0;
            r_sb_err <= 1'b0;
            r_state  <= RUN;
            r_cnt_lu <= '0;
            r_cnt_sb <= '0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_state <= w_state_nxt;
            if (w_sb_err_evt) begin
                r_sb_err <= 1'b1;
            end
            if ((r_state == LU_STALL) && (r_cnt_lu != '1)) begin
                r_cnt_lu <= r_cnt_lu + CNT_W'(1);
            end
            if ((r_state == SB_STALL) && (r_cnt_sb != '1)) begin
                r_cnt_sb <= r_cnt_sb + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit (counters narrowed to 4 bits).
module tb_hazard_fwd_unit;

    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned N_FWD   = 2;
    localparam int unsigned RA_W    = 5;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SEL_W   = 2;

    logic                     CLK;
    logic                     RST;
    logic [NUM_SRC*RA_W-1:0]  id_rs;
    logic [NUM_SRC-1:0]       id_rs_used;
    logic [NUM_SRC*RA_W-1:0]  ex_rs;
    logic [RA_W-1:0]          ex_rd;
    logic                     ex_memRead;
    logic                     ex_regWrite;
    logic [N_FWD*RA_W-1:0]    fwd_rd;
    logic [N_FWD-1:0]         fwd_regWrite;
    logic                     lng_issue;
    logic [RA_W-1:0]          lng_rd;
    logic                     lng_done;
    logic [RA_W-1:0]          lng_done_rd;
    logic                     flush;
    logic                     drain_req;
    logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;
    logic [NUM_SRC*SEL_W-1:0] id_fwd_sel;
    logic                     stall;
    logic                     drained;
    logic                     sb_err;
    logic [CNT_W-1:0]         cnt_lu;
    logic [CNT_W-1:0]         cnt_sb;

    int checks = 0;
    int errors = 0;

    hazard_fwd_unit #(
        .NUM_SRC (NUM_SRC),
        .N_FWD   (N_FWD),
        .RA_W    (RA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .ex_rs        (ex_rs),
        .ex_rd        (ex_rd),
        .ex_memRead   (ex_memRead),
        .ex_regWrite  (ex_regWrite),
        .fwd_rd       (fwd_rd),
        .fwd_regWrite (fwd_regWrite),
        .lng_issue    (lng_issue),
        .lng_rd       (lng_rd),
        .lng_done     (lng_done),
        .lng_done_rd  (lng_done_rd),
        .flush        (flush),
        .drain_req    (drain_req),
        .ex_fwd_sel   (ex_fwd_sel),
        .id_fwd_sel   (id_fwd_sel),
        .stall        (stall),
        .drained      (drained),
        .sb_err       (sb_err),
        .cnt_lu       (cnt_lu),
        .cnt_sb       (cnt_sb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle;
        id_rs        = '0;
        id_rs_used   = '0;
        ex_rs        = '0;
        ex_rd        = '0;
        ex_memRead   = 1'b0;
        ex_regWrite  = 1'b0;
        fwd_rd       = '0;
        fwd_regWrite = '0;
        lng_issue    = 1'b0;
        lng_rd       = '0;
        lng_done     = 1'b0;
        lng_done_rd  = '0;
        flush        = 1'b0;
        drain_req    = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        idle();
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall); end
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL rst_drained: got %0b want 0", drained); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb_err: got %0b want 0", sb_err); end
        checks++; if (cnt_lu !== 4'd0 || cnt_sb !== 4'd0) begin errors++; $display("FAIL rst_cnt: lu=%0d sb=%0d want 0 0", cnt_lu, cnt_sb); end
        checks++; if (ex_fwd_sel !== 4'd0 || id_fwd_sel !== 4'd0) begin errors++; $display("FAIL rst_sel: ex=%h id=%h want 0 0", ex_fwd_sel, id_fwd_sel); end
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_ex_fwd;
        idle();
        ex_rs = {5'd0, 5'd5}; fwd_rd = {5'd5, 5'd5}; fwd_regWrite = 2'b11;
        settle();
        checks++; if (ex_fwd_sel[1:0] !== 2'd1) begin errors++; $display("FAIL ex_fwd_young: got %0d want 1", ex_fwd_sel[1:0]); end
        checks++; if (ex_fwd_sel[3:2] !== 2'd0) begin errors++; $display("FAIL ex_fwd_rs0: got %0d want 0", ex_fwd_sel[3:2]); end
        fwd_regWrite = 2'b10;
        settle();
        checks++; if (ex_fwd_sel[1:0] !== 2'd2) begin errors++; $display("FAIL ex_fwd_old: got %0d want 2", ex_fwd_sel[1:0]); end
        ex_rs = '0; fwd_rd = '0; fwd_regWrite = 2'b11;
        settle();
        checks++; if (ex_fwd_sel !== 4'd0) begin errors++; $display("FAIL ex_fwd_x0: got %h want 0", ex_fwd_sel); end
        id_rs = {5'd6, 5'd9}; fwd_rd = {5'd6, 5'd9}; fwd_regWrite = 2'b11;
        settle();
        checks++; if (id_fwd_sel !== {2'd2, 2'd1}) begin errors++; $display("FAIL id_fwd: got %h want 9", id_fwd_sel); end
        idle();
        tick();
    endtask

    task automatic test_load_use;
        idle();
        ex_memRead = 1'b1; ex_regWrite = 1'b1; ex_rd = 5'd7;
        id_rs = {5'd7, 5'd0}; id_rs_used = 2'b01;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_unused: got %0b want 0", stall); end
        id_rs_used = 2'b10;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", stall); end
        tick();
        ex_memRead = 1'b0; ex_regWrite = 1'b0;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %0b want 0", stall); end
        tick();
        checks++; if (cnt_lu !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", cnt_lu); end
        ex_memRead = 1'b1; ex_regWrite = 1'b1; flush = 1'b1;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_flush: got %0b want 0", stall); end
        tick();
        idle();
        tick();
        checks++; if (cnt_lu !== 4'd1) begin errors++; $display("FAIL lu_cnt_flush: got %0d want 1", cnt_lu); end
    endtask

    task automatic test_scoreboard;
        idle();
        lng_issue = 1'b1; lng_rd = 5'd9;
        tick();
        lng_issue = 1'b0;
        id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_hold%0d: got %0b want 1", i, stall); end
            tick();
        end
        lng_done = 1'b1; lng_done_rd = 5'd9;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_done_cycle: got %0b want 1", stall); end
        tick();
        lng_done = 1'b0;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_release: got %0b want 0", stall); end
        tick();
        checks++; if (cnt_sb !== 4'd4) begin errors++; $display("FAIL sb_cnt: got %0d want 4", cnt_sb); end
        tick();
        checks++; if (cnt_sb !== 4'd4 || sb_err !== 1'b0) begin errors++; $display("FAIL sb_cnt_hold: cnt=%0d err=%0b want 4 0", cnt_sb, sb_err); end
        idle();
    endtask

    task automatic test_collision;
        idle();
        lng_issue = 1'b1; lng_rd = 5'd3;
        tick();
        lng_done = 1'b1; lng_done_rd = 5'd3;
        tick();
        idle();
        id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL col_set_wins: got %0b want 1", stall); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL col_no_err: got %0b want 0", sb_err); end
        id_rs_used = '0;
        lng_done = 1'b1; lng_done_rd = 5'd3;
        tick();
        lng_done_rd = 5'd4;
        tick();
        idle();
        settle();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL col_err_set: got %0b want 1", sb_err); end
        tick();
        tick();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL col_err_sticky: got %0b want 1", sb_err); end
    endtask

    task automatic test_drain;
        idle();
        lng_issue = 1'b1; lng_rd = 5'd10;
        tick();
        lng_rd = 5'd11;
        tick();
        idle();
        drain_req = 1'b1;
        settle();
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_two: got %0b want 0", drained); end
        lng_done = 1'b1; lng_done_rd = 5'd10;
        tick();
        lng_done = 1'b0;
        settle();
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_one: got %0b want 0", drained); end
        lng_done = 1'b1; lng_done_rd = 5'd11;
        settle();
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_clear_lag: got %0b want 0", drained); end
        tick();
        lng_done = 1'b0;
        settle();
        checks++; if (drained !== 1'b1) begin errors++; $display("FAIL drain_done: got %0b want 1", drained); end
        ex_memRead = 1'b1; ex_regWrite = 1'b1; ex_rd = 5'd8;
        id_rs = {5'd8, 5'd0}; id_rs_used = 2'b10;
        settle();
        checks++; if (drained !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL drain_stall: drained=%0b stall=%0b want 0 1", drained, stall); end
        idle();
        settle();
        checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_noreq: got %0b want 0", drained); end
        tick();
    endtask

    task automatic test_saturation_async_reset;
        idle();
        RST = 1'b1;
        settle();
        RST = 1'b0;
        tick();
        checks++; if (sb_err !== 1'b0 || cnt_sb !== 4'd0) begin errors++; $display("FAIL sat_rst: err=%0b cnt=%0d want 0 0", sb_err, cnt_sb); end
        lng_issue = 1'b1; lng_rd = 5'd12;
        tick();
        lng_issue = 1'b0;
        id_rs = {5'd12, 5'd0}; id_rs_used = 2'b10;
        repeat (20) tick();
        checks++; if (cnt_sb !== 4'd15 || stall !== 1'b1) begin errors++; $display("FAIL sat_cnt: cnt=%0d stall=%0b want 15 1", cnt_sb, stall); end
        #2;
        RST = 1'b1;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall: got %0b want 0", stall); end
        checks++; if (cnt_sb !== 4'd0 || cnt_lu !== 4'd0) begin errors++; $display("FAIL arst_cnt: sb=%0d lu=%0d want 0 0", cnt_sb, cnt_lu); end
        RST = 1'b0;
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_pend: got %0b want 0", stall); end
        idle();
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_load_use();
        test_scoreboard();
        test_collision();
        test_drain();
        test_saturation_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
